// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, byte type and default parameters
// used by both the transmit and receive sides.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_PARITY_EN    = 0;
    localparam int unsigned DEF_STOP_BITS    = 1;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input uart_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte buffer: circular register file with read/write pointers and an
// occupancy counter. Head byte is presented combinationally on rd_data_c.
module tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  uart_byte_t               wr_data,
    input  logic                     pop,
    output uart_byte_t               rd_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    uart_byte_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_c    = (count == CW'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes are framed as start, 8 data bits LSB first,
// optional even parity and 1 or 2 stop bits, with back-to-back frames when queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = DEF_PARITY_EN,
    parameter int unsigned STOP_BITS    = DEF_STOP_BITS,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned      BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t         state_q;
    tx_state_t         state_n;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_n;
    logic [2:0]        bit_q;
    logic [2:0]        bit_n;
    uart_byte_t        shift_q;
    uart_byte_t        shift_n;
    logic              par_q;
    logic              par_n;
    logic              line_n;
    logic              busy_n;
    logic              load;
    logic              push;
    logic              pop;
    logic              bit_end;
    logic              fifo_full;
    logic              fifo_empty;
    uart_byte_t        fifo_head;

    assign data_ready = !fifo_full;
    assign push       = data_valid && data_ready;
    assign bit_end    = (baud_q == BAUD_LAST);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (push),
        .wr_data   (data_in),
        .pop       (pop),
        .rd_data_c (fifo_head),
        .count     (fifo_count),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    // State, counters, shifter and registered line/busy outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_n;
            baud_q     <= baud_n;
            bit_q      <= bit_n;
            shift_q    <= shift_n;
            par_q      <= par_n;
            serial_out <= line_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        load    = 1'b0;
        pop     = 1'b0;
        line_n  = 1'b1;
        busy_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                        end else begin
                            state_n = STOP;
                        end
                    end else begin
                        bit_n   = bit_q + 3'd1;
                        shift_n = shift_q >> 1;
                    end
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_n = '0;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase

        // Head of buffer enters the shifter; parity is fixed at load time.
        if (load) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            par_n   = even_parity(fifo_head);
            baud_n  = '0;
            bit_n   = '0;
            state_n = START;
        end

        // Line level is a function of the state being entered, so it is registered.
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift_n[0];
            PARITY:  line_n = par_n;
            default: line_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE) || !fifo_empty || push;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: three instances cover no parity,
// even parity and two stop bits at 4 clocks per bit with a 4-deep buffer.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       dv0, dv1, dv2;
    logic       rdy0, rdy1, rdy2;
    logic       so0, so1, so2;
    logic       bsy0, bsy1, bsy2;
    logic [2:0] cnt0, cnt1, cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_base (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(dv0),
        .data_ready(rdy0), .serial_out(so0), .busy(bsy0), .fifo_count(cnt0));

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_par (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(dv1),
        .data_ready(rdy1), .serial_out(so1), .busy(bsy1), .fifo_count(cnt1));

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(dv2),
        .data_ready(rdy2), .serial_out(so2), .busy(bsy2), .fifo_count(cnt2));

    function automatic logic get_so(input int sel);
        if (sel == 0) return so0;
        if (sel == 1) return so1;
        return so2;
    endfunction

    function automatic logic get_busy(input int sel);
        if (sel == 0) return bsy0;
        if (sel == 1) return bsy1;
        return bsy2;
    endfunction

    function automatic logic get_rdy(input int sel);
        if (sel == 0) return rdy0;
        if (sel == 1) return rdy1;
        return rdy2;
    endfunction

    function automatic logic [2:0] get_cnt(input int sel);
        if (sel == 0) return cnt0;
        if (sel == 1) return cnt1;
        return cnt2;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic [7:0] b, input logic v);
        data_in = b;
        dv0 = (sel == 0) && v;
        dv1 = (sel == 1) && v;
        dv2 = (sel == 2) && v;
    endtask

    task automatic push(input int sel, input logic [7:0] b, input logic [2:0] exp_cnt, input string tag);
        check({tag, "_ready"}, 16'(get_rdy(sel)), 16'd1);
        drive(sel, b, 1'b1);
        tick();
        check({tag, "_count"}, 16'(get_cnt(sel)), 16'(exp_cnt));
        drive(sel, b, 1'b0);
    endtask

    // bits[0] is the first bit on the line; each bit lasts 4 clocks.
    task automatic check_frame(input int sel, input logic [15:0] bits, input int nbits,
                               input int skip, input string tag);
        for (int i = skip; i < nbits * 4; i++) begin
            logic [3:0] bi;
            tick();
            bi = 4'(i / 4);
            check($sformatf("%s_bit%0d", tag, i / 4), 16'(get_so(sel)), 16'(bits[bi]));
        end
        check({tag, "_busy_end"}, 16'(get_busy(sel)), 16'd1);
    endtask

    task automatic idle_check(input int sel, input string tag);
        tick();
        check({tag, "_busy"}, 16'(get_busy(sel)), 16'd0);
        check({tag, "_line"}, 16'(get_so(sel)), 16'd1);
        check({tag, "_count"}, 16'(get_cnt(sel)), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        drive(0, 8'h00, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d_line", s),  16'(get_so(s)),   16'd1);
            check($sformatf("rst%0d_busy", s),  16'(get_busy(s)), 16'd0);
            check($sformatf("rst%0d_count", s), 16'(get_cnt(s)),  16'd0);
            check($sformatf("rst%0d_ready", s), 16'(get_rdy(s)),  16'd1);
        end
        tick();
        tick();
        #3 reset_n = 1'b1;
        tick();

        // Single 0xA5 frame, no parity: 0,1,0,1,0,0,1,0,1,1
        push(0, 8'hA5, 3'd1, "a5_push");
        check("a5_line_at_accept", 16'(so0), 16'd1);
        check("a5_busy_at_accept", 16'(bsy0), 16'd1);
        check_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 0, "a5");
        idle_check(0, "a5_idle");

        // Even parity: 0xA5 -> 0, 0x07 -> 1
        push(1, 8'hA5, 3'd1, "pa5_push");
        check_frame(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0, "pa5");
        idle_check(1, "pa5_idle");
        push(1, 8'h07, 3'd1, "p07_push");
        check_frame(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 0, "p07");
        idle_check(1, "p07_idle");

        // Five back-to-back bytes; first is popped the edge after it lands.
        push(0, 8'h11, 3'd1, "b11");
        push(0, 8'h22, 3'd1, "b22");
        check("b_start0", 16'(so0), 16'd0);
        push(0, 8'h33, 3'd2, "b33");
        check("b_start1", 16'(so0), 16'd0);
        push(0, 8'h44, 3'd3, "b44");
        check("b_start2", 16'(so0), 16'd0);
        push(0, 8'h55, 3'd4, "b55");
        check("b_start3", 16'(so0), 16'd0);
        check("b_full_ready", 16'(rdy0), 16'd0);
        check_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10, 4, "f11");
        check("f11_still_full", 16'(rdy0), 16'd0);
        check_frame(0, 16'({1'b1, 8'h22, 1'b0}), 10, 0, "f22");
        check_frame(0, 16'({1'b1, 8'h33, 1'b0}), 10, 0, "f33");
        check_frame(0, 16'({1'b1, 8'h44, 1'b0}), 10, 0, "f44");
        check_frame(0, 16'({1'b1, 8'h55, 1'b0}), 10, 0, "f55");
        idle_check(0, "f55_idle");

        // Two stop bits: 8 high cycles, then the next start bit at once.
        push(2, 8'h00, 3'd1, "s00");
        push(2, 8'hFF, 3'd1, "sff");
        check("s2_start0", 16'(so2), 16'd0);
        check_frame(2, 16'({2'b11, 8'h00, 1'b0}), 11, 1, "s2_00");
        check_frame(2, 16'({2'b11, 8'hFF, 1'b0}), 11, 0, "s2_ff");
        idle_check(2, "s2_idle");

        // Push and pop on the same edge with two bytes queued.
        push(0, 8'h81, 3'd1, "pp81");
        push(0, 8'h82, 3'd1, "pp82");
        push(0, 8'h83, 3'd2, "pp83");
        check_frame(0, 16'({1'b1, 8'h81, 1'b0}), 10, 2, "pp_f81");
        drive(0, 8'h84, 1'b1);
        tick();
        check("pp_count_hold", 16'(cnt0), 16'd2);
        check("pp_f82_start", 16'(so0), 16'd0);
        drive(0, 8'h00, 1'b0);
        check_frame(0, 16'({1'b1, 8'h82, 1'b0}), 10, 1, "pp_f82");
        check_frame(0, 16'({1'b1, 8'h83, 1'b0}), 10, 0, "pp_f83");
        check_frame(0, 16'({1'b1, 8'h84, 1'b0}), 10, 0, "pp_f84");
        idle_check(0, "pp_idle");

        // Reset during the data bits of 0x3C with two more bytes queued.
        push(0, 8'h3C, 3'd1, "r3c");
        push(0, 8'h5A, 3'd1, "r5a");
        push(0, 8'h96, 3'd2, "r96");
        repeat (9) tick();
        check("r_pre_line", 16'(so0), 16'd0);
        check("r_pre_count", 16'(cnt0), 16'd2);
        check("r_pre_busy", 16'(bsy0), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("r_async_line", 16'(so0), 16'd1);
        check("r_async_count", 16'(cnt0), 16'd0);
        check("r_async_busy", 16'(bsy0), 16'd0);
        check("r_async_ready", 16'(rdy0), 16'd1);
        tick();
        tick();
        #3 reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check($sformatf("r_quiet_line%0d", i), 16'(so0), 16'd1);
        end
        check("r_quiet_busy", 16'(bsy0), 16'd0);
        check("r_quiet_count", 16'(cnt0), 16'd0);
        push(0, 8'hC3, 3'd1, "rc3");
        check_frame(0, 16'({1'b1, 8'hC3, 1'b0}), 10, 0, "r_fc3");
        idle_check(0, "r_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
